// File: rtl/pc_sequencer_if.sv
// pc_sequencer bus: control inputs from the fetch/branch side,
// registered PC, status and cycle count back out.
interface pc_sequencer_if #(
  parameter int D  = 10,
  parameter int CW = 16
);
  logic          start;
  logic [D-1:0]  start_addr;
  logic          stall;
  logic          halt;
  logic          branch_en;
  logic          jump_abs;
  logic [D-1:0]  target;
  logic [D-1:0]  prog_ctr;
  logic          running;
  logic          done;
  logic [CW-1:0] cycle_cnt;

  modport master (
    output start, start_addr, stall, halt,
    output branch_en, jump_abs, target,
    input  prog_ctr, running, done, cycle_cnt
  );

  modport slave (
    input  start, start_addr, stall, halt,
    input  branch_en, jump_abs, target,
    output prog_ctr, running, done, cycle_cnt
  );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: IDLE/RUN/HALTED sequencing,
// absolute and relative branch redirect, saturating cycle count.
module pc_sequencer #(
  parameter int D  = 10,
  parameter int CW = 16
) (
  input  logic           clk,
  input  logic           reset,
  pc_sequencer_if.slave  bus
);
  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HALT
  } state_t;

  state_t        state_q, state_d;
  logic [D-1:0]  pc_q, pc_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE, S_HALT: begin
        if (bus.start) begin
          state_d = S_RUN;
          pc_d    = bus.start_addr;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        if (cnt_q != {CW{1'b1}}) begin
          cnt_d = cnt_q + 1'b1;
        end
        // Priority: halt, then stall (drops branch), then branch, then step
        if (bus.halt) begin
          state_d = S_HALT;
        end else if (bus.stall) begin
          pc_d = pc_q;
        end else if (bus.branch_en) begin
          pc_d = bus.jump_abs ? bus.target : pc_q + bus.target;
        end else begin
          pc_d = pc_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.prog_ctr  = pc_q;
  assign bus.running   = (state_q == S_RUN);
  assign bus.done      = (state_q == S_HALT);
  assign bus.cycle_cnt = cnt_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed plus random bench for pc_sequencer: two instances
// (CW=16 and CW=4) share stimulus and one behavioural model.
module tb_pc_sequencer;
  localparam int D   = 10;
  localparam int MOD = 1 << D;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [D-1:0] start_addr;
  logic         stall;
  logic         halt;
  logic         branch_en;
  logic         jump_abs;
  logic [D-1:0] target;

  int checks = 0;
  int errors = 0;

  int m_pc;
  int m_cnt;
  bit m_run;
  bit m_done;

  pc_sequencer_if #(.D(D), .CW(16)) ba ();
  pc_sequencer_if #(.D(D), .CW(4))  bb ();

  assign ba.start      = start;
  assign ba.start_addr = start_addr;
  assign ba.stall      = stall;
  assign ba.halt       = halt;
  assign ba.branch_en  = branch_en;
  assign ba.jump_abs   = jump_abs;
  assign ba.target     = target;

  assign bb.start      = start;
  assign bb.start_addr = start_addr;
  assign bb.stall      = stall;
  assign bb.halt       = halt;
  assign bb.branch_en  = branch_en;
  assign bb.jump_abs   = jump_abs;
  assign bb.target     = target;

  pc_sequencer #(.D(D), .CW(16)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ba)
  );

  pc_sequencer #(.D(D), .CW(4)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bb)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int sat(int v, int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic drv(bit r, bit s, int sa, bit st, bit h,
                     bit b, bit ja, int t);
    reset      = r;
    start      = s;
    start_addr = D'(sa);
    stall      = st;
    halt       = h;
    branch_en  = b;
    jump_abs   = ja;
    target     = D'(t);
  endtask

  // Model the spec rules, advance one clock, compare both DUTs
  task automatic tick(string tag);
    if (reset) begin
      m_run = 0; m_done = 0; m_pc = 0; m_cnt = 0;
    end else if (!m_run) begin
      if (start) begin
        m_run = 1; m_done = 0;
        m_pc = int'(start_addr); m_cnt = 0;
      end
    end else begin
      m_cnt = m_cnt + 1;
      if (halt) begin
        m_run = 0; m_done = 1;
      end else if (stall) begin
        m_pc = m_pc;
      end else if (branch_en) begin
        if (jump_abs) m_pc = int'(target);
        else m_pc = (m_pc + int'(target)) % MOD;
      end else begin
        m_pc = (m_pc + 1) % MOD;
      end
    end
    @(posedge clk);
    #1;
    chk({tag, ".pc_a"},   32'(ba.prog_ctr),  32'(m_pc));
    chk({tag, ".pc_b"},   32'(bb.prog_ctr),  32'(m_pc));
    chk({tag, ".run_a"},  32'(ba.running),   32'(m_run));
    chk({tag, ".run_b"},  32'(bb.running),   32'(m_run));
    chk({tag, ".done_a"}, 32'(ba.done),      32'(m_done));
    chk({tag, ".done_b"}, 32'(bb.done),      32'(m_done));
    chk({tag, ".cnt_a"},  32'(ba.cycle_cnt), 32'(sat(m_cnt, 65535)));
    chk({tag, ".cnt_b"},  32'(bb.cycle_cnt), 32'(sat(m_cnt, 15)));
  endtask

  initial begin
    m_pc = 0; m_cnt = 0; m_run = 0; m_done = 0;
    drv(1, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) tick("reset");
    chk("reset_pc", 32'(ba.prog_ctr), 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (5) tick("idle");
    chk("idle_run", 32'(ba.running), 0);

    drv(0, 1, 10, 0, 0, 0, 0, 0);
    tick("start10");
    chk("start_pc", 32'(ba.prog_ctr), 10);
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (4) tick("step");
    chk("step_pc", 32'(ba.prog_ctr), 14);
    chk("step_cnt", 32'(ba.cycle_cnt), 4);

    drv(0, 0, 0, 0, 0, 1, 1, 20);
    tick("abs20");
    drv(0, 0, 0, 0, 0, 1, 1, 103);
    tick("abs103");
    chk("abs_pc", 32'(ba.prog_ctr), 103);
    drv(0, 0, 0, 0, 0, 1, 1, 45);
    tick("abs45");
    drv(0, 0, 0, 0, 0, 1, 0, 'h3FB);
    tick("rel_m5");
    chk("rel_m5_pc", 32'(ba.prog_ctr), 40);
    drv(0, 0, 0, 0, 0, 1, 1, 4);
    tick("abs4");
    drv(0, 0, 0, 0, 0, 1, 0, 'h3FF);
    tick("rel_m1");
    chk("rel_m1_pc", 32'(ba.prog_ctr), 3);
    drv(0, 0, 0, 0, 0, 1, 0, 0);
    tick("rel0");
    chk("rel0_pc", 32'(ba.prog_ctr), 3);

    drv(0, 0, 0, 1, 0, 1, 1, 200);
    repeat (3) tick("stall_br");
    chk("stall_pc", 32'(ba.prog_ctr), 3);
    drv(0, 1, 500, 0, 0, 0, 0, 0);
    tick("start_in_run");
    chk("start_run_pc", 32'(ba.prog_ctr), 4);
    drv(0, 0, 0, 0, 1, 1, 1, 300);
    tick("halt_br");
    chk("halt_br_pc", 32'(ba.prog_ctr), 4);
    chk("halt_done", 32'(ba.done), 1);

    drv(0, 1, 1022, 0, 0, 0, 0, 0);
    tick("start1022");
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) tick("wrap");
    chk("wrap_pc", 32'(ba.prog_ctr), 0);

    drv(0, 0, 0, 0, 0, 1, 1, 91);
    tick("abs91");
    drv(0, 0, 0, 0, 1, 0, 0, 0);
    tick("halt91");
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (10) tick("halted");
    chk("halted_pc", 32'(ba.prog_ctr), 91);
    chk("halted_run", 32'(ba.running), 0);
    drv(0, 1, 0, 0, 0, 0, 0, 0);
    tick("restart0");
    chk("restart_cnt", 32'(ba.cycle_cnt), 0);
    chk("restart_done", 32'(ba.done), 0);

    drv(0, 0, 0, 0, 0, 1, 1, 76);
    tick("abs76");
    drv(1, 0, 0, 0, 0, 0, 0, 0);
    tick("reset_mid");
    chk("reset_mid_pc", 32'(ba.prog_ctr), 0);
    drv(1, 1, 33, 0, 0, 0, 0, 0);
    tick("reset_start");
    chk("reset_start_run", 32'(ba.running), 0);

    drv(0, 1, 600, 0, 0, 0, 0, 0);
    tick("start600");
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (20) tick("sat");
    chk("sat_cnt_b", 32'(bb.cycle_cnt), 15);
    chk("sat_cnt_a", 32'(ba.cycle_cnt), 20);

    for (int i = 0; i < 400; i++) begin
      drv($urandom_range(63) == 0, $urandom_range(15) == 0,
          int'($urandom_range(MOD - 1)),
          $urandom_range(4) == 0, $urandom_range(19) == 0,
          $urandom_range(3) == 0, $urandom_range(1) == 1,
          int'($urandom_range(MOD - 1)));
      tick("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the fetch stage: holds the instruction address, steps it each cycle, and redirects it on taken branches using the target word from the branch-target lookup table (absolute target or two's-complement relative offset). It sits directly upstream of instruction memory and downstream of the decoder and branch logic. It provides the start/done handshake to the testbench and counts executed cycles.

## Interface

Parameters:
- D, 10, program-counter width; also the width of the lookup-table target word
- CW, 16, cycle-counter width

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse that begins execution; honoured in IDLE and HALTED only
- start_addr  in  D  first instruction address, loaded on an accepted start
- stall  in  1  hold the PC this cycle (RUN only)
- halt  in  1  the instruction at prog_ctr is a halt (RUN only)
- branch_en  in  1  branch at prog_ctr is taken (RUN only)
- jump_abs  in  1  1: target is an absolute address; 0: target is a signed offset
- target  in  D  target word from the branch-target lookup table
- prog_ctr  out  D  current instruction address (registered)
- running  out  1  high while in RUN
- done  out  1  high while in HALTED
- cycle_cnt  out  CW  cycles spent in RUN since the last accepted start

## Operation

- The block has three states: IDLE, RUN and HALTED. Outputs are decoded from registered state only.
- Reset values: state IDLE, prog_ctr 0, running 0, done 0, cycle_cnt 0. Reset has priority over every other input, including a reset asserted mid-RUN.
- IDLE:
  - start=1 → RUN, prog_ctr←start_addr, cycle_cnt←0.
  - All other inputs are ignored.
- RUN, evaluated each cycle in priority order:
  - halt=1 → HALTED. prog_ctr holds; a branch_en or stall in the same cycle is ignored.
  - stall=1 → prog_ctr holds. A branch_en in the same cycle is dropped; the branch logic must re-present it.
  - branch_en=1, jump_abs=1 → prog_ctr←target.
  - branch_en=1, jump_abs=0 → prog_ctr←(prog_ctr+target) mod 2^D. target is two's complement, so all-ones steps back by 1.
  - Otherwise → prog_ctr←(prog_ctr+1) mod 2^D. 2^D−1 wraps to 0.
  - cycle_cnt increments on every RUN cycle, including stall and halt cycles. It saturates at 2^CW−1 and does not wrap.
  - start is ignored.
- HALTED:
  - prog_ctr and cycle_cnt hold. done stays high.
  - start=1 → RUN, prog_ctr←start_addr, cycle_cnt←0, done falls.
- The sum uses D-bit modular arithmetic with no overflow flag. Width is never extended onto prog_ctr.

## Timing

- Single-cycle latency. A decision made in cycle n is visible on prog_ctr in cycle n+1.
- start accepted at edge k: running=1 and prog_ctr=start_addr after edge k. The first increment occurs at edge k+1.
- halt sampled at edge k: done=1 and running=0 after edge k. prog_ctr still shows the halt instruction's address.
- start and reset in the same cycle: reset wins.
- stall asserted for N consecutive cycles: prog_ctr is frozen for exactly N cycles, and cycle_cnt advances N.
- A relative branch with target=0 holds the PC. This is a legal self-loop.
- No combinational path exists from any input to any output.

## Test plan

- Reset then idle: hold reset 2 cycles, then drive start=0 for 5 cycles → prog_ctr=0, running=0, done=0, cycle_cnt=0 throughout.
- Start and step: start with start_addr=10, then 4 free cycles → prog_ctr 10,11,12,13,14; cycle_cnt=4; running=1.
- Branches:
  - At prog_ctr=20, absolute branch target=103 → prog_ctr=103 next cycle.
  - At prog_ctr=45, relative branch target=10'h3FB (−5) → prog_ctr=40.
  - At prog_ctr=4, relative branch target=10'h3FF → prog_ctr=3.
- Wrap and priority:
  - start_addr=1022, 2 free cycles → prog_ctr 1022,1023,0.
  - stall+branch_en together → PC held, branch dropped.
  - halt+branch_en together → HALTED, prog_ctr unchanged.
- Halt and restart:
  - halt at prog_ctr=91 → done=1, running=0, prog_ctr=91 held for 10 cycles; start in RUN is ignored.
  - start with start_addr=0 from HALTED → done=0, prog_ctr=0, cycle_cnt=0.
- Reset mid-run and saturation:
  - reset during RUN at prog_ctr=76 → IDLE with all outputs at reset values next cycle.
  - With CW=4, run 20 cycles → cycle_cnt stops at 15.
